// File: rtl/decode_issue_scheduler.sv
// Issue scheduler between decode and execute: scoreboards in-flight register
// writes, reserves the single register-file write port, and holds decode while
// a branch is unresolved. A taken branch produces a one-cycle flush pulse.
module decode_issue_scheduler #(
    parameter int ALU_LAT  = 2,
    parameter int LOAD_LAT = 4,
    parameter int ZERO_REG = 31,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [4:0]       rs1,
    input  logic             rs1_used,
    input  logic [4:0]       rs2,
    input  logic             rs2_used,
    input  logic [4:0]       rd,
    input  logic             rd_write,
    input  logic             is_load,
    input  logic             is_branch,
    input  logic             br_resolve,
    input  logic             br_taken,
    output logic             flush,
    output logic             wb_now,
    output logic [31:0]      pending,
    output logic [CNT_W-1:0] stall_count
);

    localparam int SB_W = $clog2(LOAD_LAT + 1);

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_BR_WAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              issue_fire;
    logic              wr_issue;
    logic [SB_W-1:0]   wr_lat;
    logic              hazard_raw, hazard_waw, hazard_port;
    logic [LOAD_LAT:1] slot_q, slot_d;
    logic [CNT_W-1:0]  stall_q, stall_d;

    assign issue_fire = issue_valid & issue_ready;
    // Branches never claim a destination even if decode flags rd_write.
    assign wr_issue   = issue_fire & ~is_branch & rd_write;
    assign wr_lat     = is_load ? SB_W'(LOAD_LAT) : SB_W'(ALU_LAT);

    // Hazard terms from current decode inputs against registered state.
    // Only ALU ops can collide on the write port: a load lands beyond any
    // writeback already scheduled, so only slot[ALU_LAT+1] needs checking.
    always_comb begin
        hazard_raw  = (rs1_used & pending[rs1]) | (rs2_used & pending[rs2]);
        hazard_waw  = rd_write & pending[rd];
        hazard_port = rd_write & ~is_load & slot_q[ALU_LAT+1];
    end

    // Per-register countdown of cycles until the in-flight write lands.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_sb
            if (gi == ZERO_REG) begin : g_zero
                assign pending[gi] = 1'b0;
            end else begin : g_entry
                localparam logic [4:0] REG_IDX = 5'(gi);
                logic [SB_W-1:0] cnt_q, cnt_d;

                // Decrement toward zero; a new write to this register reloads it.
                always_comb begin
                    cnt_d = cnt_q;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - SB_W'(1);
                    end
                    if (wr_issue && (rd == REG_IDX)) begin
                        cnt_d = wr_lat;
                    end
                end

                // Counter register, cleared on reset.
                always_ff @(posedge clk) begin
                    if (!reset_n) begin
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                assign pending[gi] = (cnt_q != '0);
            end
        end
    endgenerate

    // Write-port reservation: slots shift toward slot[1]; an issue books slot[L].
    generate
        for (genvar gi = 1; gi <= LOAD_LAT; gi++) begin : g_slot
            logic shifted_in;
            if (gi == LOAD_LAT) begin : g_top
                assign shifted_in = 1'b0;
            end else begin : g_mid
                assign shifted_in = slot_q[gi+1];
            end
            assign slot_d[gi] = shifted_in | (wr_issue & (wr_lat == SB_W'(gi)));
        end
    endgenerate

    // Slot register, cleared on reset so in-flight writebacks are discarded.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign wb_now = slot_q[1];

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: wait after an issued branch until execution resolves it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (issue_fire && is_branch) begin
                    state_d = ST_BR_WAIT;
                end
            end
            ST_BR_WAIT: begin
                if (br_resolve) begin
                    state_d = ST_RUN;
                end
            end
        endcase
    end

    // FSM outputs: ready only in RUN without hazards; flush on taken resolve.
    always_comb begin
        issue_ready = 1'b0;
        flush       = 1'b0;
        case (state_q)
            ST_RUN: begin
                issue_ready = ~(hazard_raw | hazard_waw | hazard_port);
            end
            ST_BR_WAIT: begin
                flush = br_resolve & br_taken;
            end
        endcase
    end

    // Saturating count of cycles where decode offered an instruction but was held.
    always_comb begin
        stall_d = stall_q;
        if (issue_valid && !issue_ready && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_count = stall_q;

endmodule

// File: tb/tb_decode_issue_scheduler.sv
// Self-checking bench for decode_issue_scheduler. The reference model tracks
// absolute writeback cycles per register and a set of booked writeback cycles.
module tb_decode_issue_scheduler;

    localparam int ALU_LAT  = 2;
    localparam int LOAD_LAT = 4;
    localparam int ZERO_REG = 31;
    localparam int CNT_W    = 16;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             issue_valid = 1'b0;
    logic             issue_ready;
    logic [4:0]       rs1 = '0;
    logic             rs1_used = 1'b0;
    logic [4:0]       rs2 = '0;
    logic             rs2_used = 1'b0;
    logic [4:0]       rd = '0;
    logic             rd_write = 1'b0;
    logic             is_load = 1'b0;
    logic             is_branch = 1'b0;
    logic             br_resolve = 1'b0;
    logic             br_taken = 1'b0;
    logic             flush;
    logic             wb_now;
    logic [31:0]      pending;
    logic [CNT_W-1:0] stall_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    decode_issue_scheduler #(
        .ALU_LAT (ALU_LAT),
        .LOAD_LAT(LOAD_LAT),
        .ZERO_REG(ZERO_REG),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .issue_valid(issue_valid),
        .issue_ready(issue_ready),
        .rs1        (rs1),
        .rs1_used   (rs1_used),
        .rs2        (rs2),
        .rs2_used   (rs2_used),
        .rd         (rd),
        .rd_write   (rd_write),
        .is_load    (is_load),
        .is_branch  (is_branch),
        .br_resolve (br_resolve),
        .br_taken   (br_taken),
        .flush      (flush),
        .wb_now     (wb_now),
        .pending    (pending),
        .stall_count(stall_count)
    );

    // ---------------- reference model ----------------
    int          cyc = 0;
    int          wb_time [32];   // last cycle at which register r still reads pending
    bit          wb_at [int];    // set of cycles that carry a writeback
    bit          m_br = 1'b0;    // waiting for branch resolution
    int          m_stall = 0;
    bit          exp_ready, exp_flush, exp_wb;
    logic [31:0] exp_pend;

    function automatic void model_clear();
        for (int r = 0; r < 32; r++) wb_time[r] = -100;
        wb_at.delete();
        m_br    = 1'b0;
        m_stall = 0;
    endfunction

    function automatic bit m_pending(input int r);
        return (r != ZERO_REG) && (cyc <= wb_time[r]);
    endfunction

    function automatic void model_predict();
        int lat;
        bit raw, waw, port;
        lat = is_load ? LOAD_LAT : ALU_LAT;
        for (int r = 0; r < 32; r++) exp_pend[r] = m_pending(r);
        raw  = (rs1_used && m_pending(int'(rs1))) || (rs2_used && m_pending(int'(rs2)));
        waw  = rd_write && m_pending(int'(rd));
        port = rd_write && (lat < LOAD_LAT) && wb_at.exists(cyc + lat);
        exp_ready = !m_br && !(raw || waw || port);
        exp_flush = m_br && br_resolve && br_taken;
        exp_wb    = wb_at.exists(cyc);
    endfunction

    // Advance one clock edge, updating the model with the inputs seen at that edge.
    task automatic tick();
        bit fire;
        int lat;
        model_predict();
        fire = issue_valid && exp_ready;
        lat  = is_load ? LOAD_LAT : ALU_LAT;
        @(posedge clk);
        if (!reset_n) begin
            model_clear();
        end else begin
            if (issue_valid && !exp_ready && m_stall < (2**CNT_W - 1)) m_stall++;
            if (m_br && br_resolve) begin
                m_br = 1'b0;
            end else if (fire && is_branch) begin
                m_br = 1'b1;
            end else if (fire && rd_write) begin
                wb_at[cyc + lat] = 1'b1;
                if (int'(rd) != ZERO_REG) wb_time[rd] = cyc + lat;
            end
            if (fire)
                $display("cyc %0d issue rd=%0d wr=%0b load=%0b branch=%0b", cyc, rd, rd_write, is_load, is_branch);
        end
        cyc++;
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic au, input logic [4:0] b,
                         input logic bu, input logic [4:0] d, input logic dw, input logic ld,
                         input logic br);
        issue_valid = v; rs1 = a; rs1_used = au; rs2 = b; rs2_used = bu;
        rd = d; rd_write = dw; is_load = ld; is_branch = br;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        br_resolve = 1'b0;
        br_taken   = 1'b0;
    endtask

    task automatic apply_reset();
        idle();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        model_predict();
        @(negedge clk);
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b expected 1", issue_ready); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %0b expected 0", flush); end
        checks++; if (wb_now !== 1'b0) begin errors++; $display("FAIL reset_wb_now: got %0b expected 0", wb_now); end
        checks++; if (pending !== 32'h0) begin errors++; $display("FAIL reset_pending: got %08h expected 0", pending); end
        checks++; if (stall_count !== '0) begin errors++; $display("FAIL reset_stall: got %0d expected 0", stall_count); end
        tick();
    endtask

    task automatic test_raw();
        apply_reset();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0);
        model_predict();
        @(negedge clk);
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL raw_writer_ready: got %0b expected 1", issue_ready); end
        tick();
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            model_predict();
            @(negedge clk);
            checks++; if (issue_ready !== (i == 2)) begin errors++; $display("FAIL raw_reader_ready[%0d]: got %0b expected %0b", i, issue_ready, (i == 2)); end
            checks++; if (pending[1] !== (i < 2)) begin errors++; $display("FAIL raw_pending1[%0d]: got %0b expected %0b", i, pending[1], (i < 2)); end
            tick();
        end
        idle();
        model_predict();
        @(negedge clk);
        checks++; if (stall_count !== CNT_W'(2)) begin errors++; $display("FAIL raw_stall_count: got %0d expected 2", stall_count); end
        tick();
    endtask

    task automatic test_port();
        int rd_tab [3] = '{5, 6, 7};
        int ld_tab [3] = '{1, 0, 0};
        int exp_wait [3] = '{0, 0, 1};
        int waits;
        int pulses = 0;
        bit fired;
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'(rd_tab[k]), 1'b1, ld_tab[k][0], 1'b0);
            waits = 0;
            for (int c = 0; c < 8; c++) begin
                model_predict();
                @(negedge clk);
                checks++; if (issue_ready !== exp_ready) begin errors++; $display("FAIL port_ready: got %0b expected %0b", issue_ready, exp_ready); end
                checks++; if (wb_now !== exp_wb) begin errors++; $display("FAIL port_wb_now: got %0b expected %0b", wb_now, exp_wb); end
                if (wb_now === 1'b1) pulses++;
                fired = exp_ready;
                tick();
                if (fired) break;
                waits++;
            end
            checks++; if (waits != exp_wait[k]) begin errors++; $display("FAIL port_wait[%0d]: got %0d expected %0d", k, waits, exp_wait[k]); end
        end
        idle();
        for (int c = 0; c < 6; c++) begin
            model_predict();
            @(negedge clk);
            checks++; if (wb_now !== exp_wb) begin errors++; $display("FAIL port_wb_tail: got %0b expected %0b", wb_now, exp_wb); end
            if (wb_now === 1'b1) pulses++;
            tick();
        end
        checks++; if (pulses != 3) begin errors++; $display("FAIL port_wb_pulses: got %0d expected 3", pulses); end
    endtask

    task automatic test_zero_reg();
        int pulses = 0;
        apply_reset();
        drive(1'b1, 5'd31, 1'b1, 5'd31, 1'b1, 5'd31, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 9; c++) begin
            if (c == 6) idle();
            model_predict();
            @(negedge clk);
            if (c < 6) begin
                checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL xzr_ready[%0d]: got %0b expected 1", c, issue_ready); end
            end
            checks++; if (pending !== 32'h0) begin errors++; $display("FAIL xzr_pending[%0d]: got %08h expected 0", c, pending); end
            if (wb_now === 1'b1) pulses++;
            tick();
        end
        checks++; if (pulses != 6) begin errors++; $display("FAIL xzr_wb_pulses: got %0d expected 6", pulses); end
        checks++; if (stall_count !== '0) begin errors++; $display("FAIL xzr_stall: got %0d expected 0", stall_count); end
    endtask

    task automatic test_branch();
        apply_reset();
        br_resolve = 1'b1; br_taken = 1'b1;
        model_predict();
        @(negedge clk);
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL br_resolve_in_run: got %0b expected 0", flush); end
        tick();
        br_resolve = 1'b0; br_taken = 1'b0;
        drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        model_predict();
        @(negedge clk);
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL br_issue_ready: got %0b expected 1", issue_ready); end
        tick();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            model_predict();
            @(negedge clk);
            checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL br_wait_ready[%0d]: got %0b expected 0", i, issue_ready); end
            checks++; if (flush !== 1'b0) begin errors++; $display("FAIL br_wait_flush[%0d]: got %0b expected 0", i, flush); end
            tick();
        end
        br_resolve = 1'b1; br_taken = 1'b1;
        model_predict();
        @(negedge clk);
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL br_taken_flush: got %0b expected 1", flush); end
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL br_taken_ready: got %0b expected 0", issue_ready); end
        tick();
        br_resolve = 1'b0; br_taken = 1'b0;
        model_predict();
        @(negedge clk);
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL br_after_flush: got %0b expected 0", flush); end
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL br_back_to_run: got %0b expected 1", issue_ready); end
        tick();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        model_predict();
        @(negedge clk);
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL br2_issue_ready: got %0b expected 1", issue_ready); end
        tick();
        idle();
        br_resolve = 1'b1; br_taken = 1'b0;
        model_predict();
        @(negedge clk);
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL br_not_taken_flush: got %0b expected 0", flush); end
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL br_not_taken_ready: got %0b expected 0", issue_ready); end
        tick();
        idle();
        model_predict();
        @(negedge clk);
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL br2_back_to_run: got %0b expected 1", issue_ready); end
        checks++; if (stall_count !== CNT_W'(4)) begin errors++; $display("FAIL br_stall_count: got %0d expected 4", stall_count); end
        tick();
    endtask

    task automatic test_waw();
        int waits = 0;
        bit fired;
        apply_reset();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 8; c++) begin
            model_predict();
            @(negedge clk);
            checks++; if (issue_ready !== exp_ready) begin errors++; $display("FAIL waw_ready[%0d]: got %0b expected %0b", c, issue_ready, exp_ready); end
            fired = exp_ready;
            tick();
            if (fired) break;
            waits++;
        end
        checks++; if (waits != LOAD_LAT) begin errors++; $display("FAIL waw_wait: got %0d expected %0d", waits, LOAD_LAT); end
        idle();
        for (int i = 0; i < 3; i++) begin
            model_predict();
            @(negedge clk);
            checks++; if (pending[2] !== (i < ALU_LAT)) begin errors++; $display("FAIL waw_reload[%0d]: got %0b expected %0b", i, pending[2], (i < ALU_LAT)); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        model_predict();
        @(negedge clk);
        checks++; if ($countones(pending) != 3) begin errors++; $display("FAIL mid_pending_count: got %0d expected 3", $countones(pending)); end
        checks++; if (pending !== exp_pend) begin errors++; $display("FAIL mid_pending: got %08h expected %08h", pending, exp_pend); end
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL mid_br_wait_ready: got %0b expected 0", issue_ready); end
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        idle();
        br_resolve = 1'b1; br_taken = 1'b1;
        model_predict();
        @(negedge clk);
        checks++; if (pending !== 32'h0) begin errors++; $display("FAIL mid_rst_pending: got %08h expected 0", pending); end
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %0b expected 1", issue_ready); end
        checks++; if (stall_count !== '0) begin errors++; $display("FAIL mid_rst_stall: got %0d expected 0", stall_count); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL mid_rst_flush: got %0b expected 0", flush); end
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            model_predict();
            @(negedge clk);
            checks++; if (wb_now !== 1'b0) begin errors++; $display("FAIL mid_rst_wb[%0d]: got %0b expected 0", i, wb_now); end
            tick();
        end
    endtask

    task automatic test_random();
        int tab [6] = '{0, 1, 2, 3, 4, 31};
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            reset_n     = ($urandom_range(0, 99) != 0);
            issue_valid = ($urandom_range(0, 9) < 7);
            rs1         = 5'(tab[$urandom_range(0, 5)]);
            rs1_used    = 1'($urandom_range(0, 1));
            rs2         = 5'(tab[$urandom_range(0, 5)]);
            rs2_used    = 1'($urandom_range(0, 1));
            rd          = 5'(tab[$urandom_range(0, 5)]);
            rd_write    = ($urandom_range(0, 3) != 0);
            is_load     = ($urandom_range(0, 9) < 3);
            is_branch   = ($urandom_range(0, 9) == 0);
            br_resolve  = ($urandom_range(0, 3) == 0);
            br_taken    = 1'($urandom_range(0, 1));
            model_predict();
            @(negedge clk);
            checks++; if (issue_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready[%0d]: got %0b expected %0b", i, issue_ready, exp_ready); end
            checks++; if (flush !== exp_flush) begin errors++; $display("FAIL rnd_flush[%0d]: got %0b expected %0b", i, flush, exp_flush); end
            checks++; if (wb_now !== exp_wb) begin errors++; $display("FAIL rnd_wb_now[%0d]: got %0b expected %0b", i, wb_now, exp_wb); end
            checks++; if (pending !== exp_pend) begin errors++; $display("FAIL rnd_pending[%0d]: got %08h expected %08h", i, pending, exp_pend); end
            checks++; if (stall_count !== CNT_W'(m_stall)) begin errors++; $display("FAIL rnd_stall[%0d]: got %0d expected %0d", i, stall_count, m_stall); end
            tick();
        end
        reset_n = 1'b1;
        idle();
    endtask

    initial begin
        model_clear();
        test_reset();
        test_raw();
        test_port();
        test_zero_reg();
        test_branch();
        test_waw();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_issue_scheduler.md
Name: decode_issue_scheduler

Overview:
- Issue controller between the instruction-decode stage and the execution datapath.
- Keeps a per-register scoreboard of in-flight writes to the 32×64 register file and a reservation map for the single register-file write port.
- Holds decode (issue_ready=0) on RAW/WAW hazards, write-port collisions and unresolved branches.
- Emits a one-cycle flush when a branch resolves taken.

Parameters:
- ALU_LAT, 2, cycles from issue to register writeback for non-load ops (1 ≤ ALU_LAT < LOAD_LAT).
- LOAD_LAT, 4, cycles from issue to register writeback for loads (MemtoReg path).
- ZERO_REG, 31, register index hardwired to zero (XZR); never scoreboarded.
- CNT_W, 16, width of stall-cycle counter.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- issue_valid  in  1  decode presents an instruction this cycle
- issue_ready  out  1  scheduler accepts it; issue_fire = issue_valid & issue_ready
- rs1  in  5  first source register (Instruction[9:5])
- rs1_used  in  1  rs1 is read
- rs2  in  5  second source register (Rm or Rt, per Reg2Loc)
- rs2_used  in  1  rs2 is read
- rd  in  5  destination register (Instruction[4:0])
- rd_write  in  1  instruction writes rd (RegWrite)
- is_load  in  1  instruction is a load (MemRead)
- is_branch  in  1  instruction is B/CBZ/CBNZ
- br_resolve  in  1  execution reports branch outcome this cycle
- br_taken  in  1  outcome; valid with br_resolve (PCSrc)
- flush  out  1  one-cycle pulse: discard fetched/decoded instruction
- wb_now  out  1  a scheduled writeback occurs this cycle
- pending  out  32  bit r = register r has an outstanding write
- stall_count  out  CNT_W  saturating count of cycles with issue_valid & !issue_ready

Behaviour:
- Reset (reset_n=0 at posedge): all scoreboard counters 0, all write-port slots 0, state RUN, stall_count 0. Outputs after reset: issue_ready=1 (if no hazard on current inputs), flush=0, wb_now=0, pending=0.
- Scoreboard:
  - cnt[r], width clog2(LOAD_LAT+1); pending[r] = (cnt[r]!=0), registered view.
  - Each cycle every nonzero cnt decrements by 1.
  - On issue_fire with rd_write and rd!=ZERO_REG: cnt[rd] <= (is_load ? LOAD_LAT : ALU_LAT). The load overrides the decrement for that entry.
  - cnt[ZERO_REG] is constant 0.
- Write-port map:
  - slot[1..LOAD_LAT]; slot[k]=1 means a writeback happens k cycles from now.
  - Each cycle slot[k] <= slot[k+1], with slot[LOAD_LAT] <= 0.
  - Issue with latency L sets slot[L] after the shift.
  - wb_now = slot[1].
- Hazard terms (combinational on current inputs and registered state):
  - raw = (rs1_used & pending[rs1]) | (rs2_used & pending[rs2]). Register 31 is never pending. No bypass: a reader waits until cnt reaches 0.
  - waw = rd_write & pending[rd].
  - port = rd_write & (L<LOAD_LAT) & slot[L+1].
- FSM, two states:
  - RUN: issue_ready = !(raw|waw|port). On issue_fire & is_branch → BR_WAIT. rd_write is ignored for branches (no scoreboard/slot update).
  - BR_WAIT: issue_ready=0. On br_resolve → RUN; flush = br_taken in that cycle, combinational with br_resolve. Scoreboard and slots keep counting (in-flight writes complete).
  - br_resolve in RUN is ignored; flush stays 0.
- Same-cycle issue and expiry: a counter going 1→0 still reads pending in that cycle, so the reader issues the following cycle.
- stall_count increments when issue_valid & !issue_ready and saturates at all-ones.
- Reset asserted mid-operation discards all in-flight state. issue_ready=1 the cycle after release.

Test Plan:
- Reset, then ALU write X1 (ALU_LAT=2) followed immediately by a reader of X1 → pending[1]=1 for 2 cycles; reader stalls 2 cycles, issues on cycle 3; stall_count=2.
- Load to X5 (LOAD_LAT=4), then ALU write to X6 one cycle later (L=2 lands on slot 3, free) and one two cycles later (slot[3] occupied) → first issues, second stalls 1 cycle; wb_now pulses on exactly the scheduled cycles, never twice in one cycle.
- Writes to X31 and reads of X31 back-to-back → never pending, never stall, wb_now still pulses.
- CBZ issued → issue_ready=0 until br_resolve; resolve with br_taken=1 → flush=1 for exactly that cycle, state RUN next cycle; resolve with br_taken=0 → flush=0.
- Load to X2 then an ALU write to X2 → WAW stall until cnt[2]=0; pending[2] reloads to ALU_LAT.
- Assert reset_n=0 with 3 pending regs and BR_WAIT active → next cycle pending=0, slots clear, issue_ready=1, stall_count=0.
